// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op codes, FSM states and
// the default datapath width. The ALU control decoder imports the same
// op-code constants. Optional divider is built when ALU_DIV_EN is defined.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_MULT = 3'b101;
    localparam logic [2:0] ALU_DIV  = 3'b110;
    localparam logic [2:0] ALU_RSV  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_muldiv_unit_if.sv
// Request/response bundle between the pipeline (master) and the ALU (slave).
interface alu_muldiv_unit_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
);
    logic             start;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, alu_control, a, b,
        input  result, zero, hi, lo, busy, done
    );

    modport slave (
        input  start, alu_control, a, b,
        output result, zero, hi, lo, busy, done
    );
endinterface

// File: rtl/alu_muldiv_core.sv
// Iterative signed multiply/divide datapath. Works on operand magnitudes:
// shift-add for multiply, restoring subtract for divide, then applies the
// sign correction combinationally for the FIXUP write. The divide path
// exists only when ALU_DIV_EN is defined.
module alu_muldiv_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             op_div,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi_fix,
    output logic [WIDTH-1:0] lo_fix
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      count;
    // acc: upper product half / partial remainder; low: multiplier / quotient
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   low;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   acc_nx;
    logic [WIDTH-1:0]   low_nx;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic               neg_lo;

`ifdef ALU_DIV_EN
    logic               is_div;
    logic               neg_hi;
    logic [WIDTH:0]     shifted;
    logic               fits;
`else
    logic               unused_div;
    assign unused_div = op_div;
`endif

    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;
    assign last  = (count == CW'(WIDTH - 1));

    // Next value of the iteration registers for one step
    always_comb begin
        sum    = {1'b0, acc} + (low[0] ? {1'b0, divisor} : '0);
        acc_nx = sum[WIDTH:1];
        low_nx = {sum[0], low[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        shifted = {acc, low[WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor});
        if (is_div) begin
            // A successful subtract always leaves less than divisor, so the
            // low WIDTH bits of the difference are the full remainder.
            if (fits) begin
                acc_nx = shifted[WIDTH-1:0] - divisor;
                low_nx = {low[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = shifted[WIDTH-1:0];
                low_nx = {low[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Iteration registers: load magnitudes on accept, advance once per RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            low     <= '0;
            divisor <= '0;
            count   <= '0;
            neg_lo  <= 1'b0;
`ifdef ALU_DIV_EN
            is_div  <= 1'b0;
            neg_hi  <= 1'b0;
`endif
        end else if (load) begin
            acc     <= '0;
            low     <= a_mag;
            divisor <= b_mag;
            count   <= '0;
            neg_lo  <= a[WIDTH-1] ^ b[WIDTH-1];
`ifdef ALU_DIV_EN
            is_div  <= op_div;
            neg_hi  <= a[WIDTH-1];
`endif
        end else if (step) begin
            acc   <= acc_nx;
            low   <= low_nx;
            count <= count + CW'(1);
        end
    end

    // Two's-complement sign correction of the finished magnitudes
    always_comb begin
        prod     = {acc, low};
        prod_fix = neg_lo ? -prod : prod;
        hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix   = prod_fix[WIDTH-1:0];
`ifdef ALU_DIV_EN
        if (is_div) begin
            lo_fix = neg_lo ? -low : low;
            hi_fix = neg_hi ? -acc : acc;
        end
`endif
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Execute-stage ALU: single-cycle add/sub/and/or/slt, iterative signed
// mult/div into HI/LO, with a start/busy/done handshake for pipeline stalls.
// Define ALU_DIV_EN to build the divider; otherwise op 110 acts as op 111.
module alu_muldiv_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    alu_muldiv_unit_if.slave   bus
);
    alu_state_e       state;
    alu_state_e       state_nx;

    logic             accept;
    logic             iter_op;
    logic             div_zero;
    logic             core_load;
    logic             core_step;
    logic             core_last;
    logic             wr_single;
    logic             wr_fix;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;
    logic [WIDTH-1:0] alu_res;

    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             zero_q;

    assign accept = bus.start && (state == ST_IDLE);

`ifdef ALU_DIV_EN
    assign div_zero = (bus.alu_control == ALU_DIV) && (bus.b == '0);
    assign iter_op  = (bus.alu_control == ALU_MULT) ||
                      ((bus.alu_control == ALU_DIV) && (bus.b != '0));
`else
    assign div_zero = 1'b0;
    assign iter_op  = (bus.alu_control == ALU_MULT);
`endif

    alu_muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (core_load),
        .op_div (bus.alu_control == ALU_DIV),
        .step   (core_step),
        .a      (bus.a),
        .b      (bus.b),
        .last   (core_last),
        .hi_fix (core_hi),
        .lo_fix (core_lo)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-state control strobes
    always_comb begin
        state_nx  = state;
        core_load = 1'b0;
        core_step = 1'b0;
        wr_single = 1'b0;
        wr_fix    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (iter_op) begin
                        core_load = 1'b1;
                        state_nx  = ST_RUN;
                    end else begin
                        wr_single = 1'b1;
                        state_nx  = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                core_step = 1'b1;
                if (core_last) begin
                    state_nx = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                wr_fix   = 1'b1;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Single-cycle operations; reserved codes (and div without divider) give 0
    always_comb begin
        case (bus.alu_control)
            ALU_ADD: alu_res = bus.a + bus.b;
            ALU_SUB: alu_res = bus.a - bus.b;
            ALU_AND: alu_res = bus.a & bus.b;
            ALU_OR:  alu_res = bus.a | bus.b;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: alu_res = '0;
        endcase
    end

    // Output registers: hold until the next completion; hi/lo only on mult/div
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            zero_q   <= 1'b0;
        end else if (wr_fix) begin
            hi_q     <= core_hi;
            lo_q     <= core_lo;
            result_q <= core_lo;
            zero_q   <= (core_lo == '0);
        end else if (wr_single) begin
            if (div_zero) begin
                lo_q     <= '1;
                hi_q     <= bus.a;
                result_q <= '1;
                zero_q   <= 1'b0;
            end else begin
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
            end
        end
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.busy   = (state == ST_RUN) || (state == ST_FIXUP);
    assign bus.done   = (state == ST_DONE);

endmodule
